// File: rtl/fir_div_pkg.sv
// Shared constants and types for the FIR iterative signed divider.
// Imported by fir_div_step and fir_div_32s_6s_seq.
package fir_div_pkg;

  localparam int DIV_DIVIDEND_W = 32;
  localparam int DIV_DIVISOR_W  = 6;
  localparam int DIV_PREM_W     = 7;
  localparam int DIV_LAT        = 34;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  typedef logic [5:0] div_cnt_t;

endpackage

// File: rtl/fir_div_step.sv
// One radix-2 restoring step on magnitudes: shift in a dividend bit,
// trial-subtract the divisor, keep or restore, emit one quotient bit.
module fir_div_step
  import fir_div_pkg::*;
#(
  parameter int PREM_W = DIV_PREM_W
) (
  input  logic [PREM_W-1:0] i_prem,
  input  logic              i_bit,
  input  logic [PREM_W-1:0] i_dmag,
  output logic [PREM_W-1:0] o_prem,
  output logic              o_qbit
);

  logic [PREM_W:0] w_sh;
  logic [PREM_W:0] w_dm;

  assign w_sh   = {i_prem, i_bit};
  assign w_dm   = {1'b0, i_dmag};
  assign o_qbit = (w_sh >= w_dm);
  assign o_prem = o_qbit ? PREM_W'(w_sh - w_dm)
                         : PREM_W'(w_sh);

endmodule

// File: rtl/fir_div_32s_6s_seq.sv
// Iterative signed divider (32s / 6s), restoring radix-2, fixed latency.
// Macro FIR_DIV_SAT_EN: saturate -2^31 / -1 to 2^31-1 instead of wrapping.
module fir_div_32s_6s_seq
  import fir_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIV_DIVIDEND_W,
  parameter int din1_WIDTH = DIV_DIVISOR_W,
  parameter int dout_WIDTH = DIV_DIVIDEND_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int QW = din0_WIDTH;
  localparam int PW = din1_WIDTH + 1;
  localparam logic [dout_WIDTH-1:0] QMIN =
    {1'b1, {(dout_WIDTH-1){1'b0}}};
  localparam logic [dout_WIDTH-1:0] QMAX = ~QMIN;

  // The instance tag has no function; dout must match the dividend width.
  if (ID < 0 || dout_WIDTH != din0_WIDTH) begin : g_cfg_invalid
  end

  div_state_t r_state;
  div_state_t w_next;
  div_cnt_t   r_cnt;

  logic [QW-1:0]         r_q;
  logic [PW-1:0]         r_prem;
  logic [PW-1:0]         r_dmag;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dz;
  logic [din1_WIDTH-1:0] r_lo;
  logic [dout_WIDTH-1:0] r_dout;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_dbz;
`ifdef FIR_DIV_SAT_EN
  logic                  r_ovf;
  logic                  w_ovf;
`endif

  logic                  w_a_neg;
  logic [QW-1:0]         w_a_mag;
  logic [PW-1:0]         w_d_ext;
  logic [PW-1:0]         w_d_mag;
  logic [PW-1:0]         w_step_prem;
  logic                  w_step_q;
  logic [dout_WIDTH-1:0] w_qmag;
  logic [dout_WIDTH-1:0] w_qfix;
  logic [din1_WIDTH-1:0] w_rmag;
  logic [din1_WIDTH-1:0] w_rfix;

  // Operand magnitudes; -2^31 maps to 0x8000_0000 unsigned.
  assign w_a_neg = din0[QW-1];
  assign w_a_mag = w_a_neg ? -din0 : din0;
  assign w_d_ext = {din1[din1_WIDTH-1], din1};
  assign w_d_mag = w_d_ext[PW-1] ? -w_d_ext : w_d_ext;
`ifdef FIR_DIV_SAT_EN
  assign w_ovf = (din0 == {1'b1, {(QW-1){1'b0}}})
               && (din1 == {din1_WIDTH{1'b1}});
`endif

  fir_div_step #(
    .PREM_W (PW)
  ) u_step (
    .i_prem (r_prem),
    .i_bit  (r_q[QW-1]),
    .i_dmag (r_dmag),
    .o_prem (w_step_prem),
    .o_qbit (w_step_q)
  );

  // Sign fix-up and divide-by-zero substitution of the final result.
  assign w_qmag = dout_WIDTH'(r_q);
  assign w_rmag = din1_WIDTH'(r_prem);
  assign w_rfix = r_dz    ? r_lo
                : r_neg_r ? -w_rmag
                :           w_rmag;
`ifdef FIR_DIV_SAT_EN
  assign w_qfix = r_dz    ? (r_neg_r ? QMIN : QMAX)
                : r_ovf   ? QMAX
                : r_neg_q ? -w_qmag
                :           w_qmag;
`else
  assign w_qfix = r_dz    ? (r_neg_r ? QMIN : QMAX)
                : r_neg_q ? -w_qmag
                :           w_qmag;
`endif

  // State register, advanced only on enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else if (ce) begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_cnt == div_cnt_t'(1)) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // Datapath: capture, iterate one bit per cycle, then publish results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_q     <= '0;
      r_prem  <= '0;
      r_dmag  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_lo    <= '0;
      r_dout  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef FIR_DIV_SAT_EN
      r_ovf   <= 1'b0;
`endif
    end else if (ce) begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= div_cnt_t'(din0_WIDTH);
            r_q     <= w_a_mag;
            r_prem  <= '0;
            r_dmag  <= w_d_mag;
            r_neg_q <= w_a_neg ^ din1[din1_WIDTH-1];
            r_neg_r <= w_a_neg;
            r_dz    <= (din1 == '0);
            r_lo    <= din0[din1_WIDTH-1:0];
`ifdef FIR_DIV_SAT_EN
            r_ovf   <= w_ovf;
`endif
          end
        end
        CALC: begin
          r_prem <= w_step_prem;
          r_q    <= {r_q[QW-2:0], w_step_q};
          r_cnt  <= r_cnt - 1'b1;
        end
        FIX: begin
          r_dout <= w_qfix;
          r_rem  <= w_rfix;
          r_dbz  <= r_dz;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign rem  = r_rem;
  assign dbz  = r_dbz;

endmodule

// File: doc/fir_div_32s_6s_seq.md
Name: fir_div_32s_6s_seq

Overview:
- Iterative signed divider, the arithmetic inverse of the FIR pipelined signed multiplier. It rescales accumulated FIR products by a small signed coefficient, for normalisation and gain recovery.
- Radix-2 restoring algorithm on magnitudes with sign fix-up. One quotient bit per enabled cycle.
- Start/done handshake. Fixed, data-independent latency.
- Integer semantics: quotient truncates toward zero; remainder takes the sign of the dividend.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 32, dividend width (signed).
- din1_WIDTH, 6, divisor width (signed).
- dout_WIDTH, 32, quotient width; must equal din0_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; sampled only when ce=1 and busy=0.
- din0  in  din0_WIDTH  signed dividend; captured with start.
- din1  in  din1_WIDTH  signed divisor; captured with start.
- busy  out  1  high from the cycle after start acceptance through the done cycle.
- done  out  1  one-cycle pulse; results valid.
- dout  out  dout_WIDTH  signed quotient; held until next done.
- rem  out  din1_WIDTH  signed remainder; held until next done.
- dbz  out  1  divide-by-zero flag; updated with done, held.

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, dout=0, rem=0, dbz=0; internal registers cleared.
- Reset asserted mid-operation aborts immediately. No done follows; the next start after deassert is a fresh operation.
- All transitions occur only on clk edges with ce=1. ce=0 freezes the state, the counter and all outputs, including a done pulse, which then lasts until the next ce=1 edge.
- States:
  - IDLE: start=1 → capture the operands. Compute |din0| (din0_WIDTH+1 bits, so -2^31 is safe) and |din1|. Record the signs. Set counter=din0_WIDTH. Go to CALC; busy=1.
  - CALC: shift the partial remainder left, bringing in the next dividend magnitude bit MSB-first. Trial-subtract |divisor|. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0. Decrement the counter. At counter==1 → FIX.
  - FIX: negate the quotient if the operand signs differ. Negate the remainder if the dividend is negative. Go to DONE.
  - DONE: register dout, rem and dbz; done=1 for this cycle; busy drops on the next enabled edge → IDLE.
- Latency: done is high on the enabled edge exactly din0_WIDTH+2 (default 34) enabled cycles after the start-sampling edge. This holds for every operand, including dbz.
- start while busy=1 is ignored; no queueing. start in the DONE cycle is ignored. Back-to-back throughput is one operation per din0_WIDTH+3 enabled cycles.
- Divide by zero (din1==0): CALC still runs for a fixed latency, but its result is discarded. dbz=1 and rem=din0[din1_WIDTH-1:0]. dout=2^31-1 if din0>=0, else -2^31.
- Overflow (din0=-2^31, din1=-1): dout wraps to -2^31, rem=0, dbz=0.
- Width rules: the divisor magnitude is at most 32 and fits in 7 bits unsigned. The partial remainder is 7 bits. The remainder magnitude is always below |divisor|, so it fits in din1_WIDTH signed.

Optional Feature:
- Macro FIR_DIV_SAT_EN.
- Defined: for the overflow case (-2^31 / -1), dout saturates to 2^31-1, rem=0, and dbz stays 0.
- Undefined: the wrap behaviour above applies.
- All other results are identical with or without the macro.

Decomposition:
- Package fir_div_pkg:
  - constants DIV_DIVIDEND_W=32, DIV_DIVISOR_W=6, DIV_PREM_W=7, DIV_LAT=34;
  - typedef div_state_t {IDLE, CALC, FIX, DONE};
  - typedef div_cnt_t (6 bits).
- One natural sub-module: fir_div_step. It is combinational: partial remainder, next dividend bit and divisor magnitude in; new partial remainder and quotient bit out. It is instantiated once inside the CALC datapath.

Test Plan:
- ce=1; start with din0=100, din1=7 → done exactly 34 cycles later; dout=14, rem=2, dbz=0; busy high throughout.
- Sign mix → -100/7: dout=-14, rem=-2. 100/-7: dout=-14, rem=2. -100/-7: dout=14, rem=-2.
- din0=-5, din1=0 → dbz=1, dout=-2^31, rem=-5 at cycle 34. din0=5, din1=0 → dbz=1, dout=2^31-1, rem=5.
- din0=-2^31, din1=-1 → dout=-2^31 without FIR_DIV_SAT_EN, 2^31-1 with it; rem=0. Also din0=-2^31, din1=-32 → dout=2^26, rem=0.
- ce held low for 10 cycles mid-CALC → done arrives at cycle 44 with the correct result. A second start pulsed while busy is ignored: exactly one done.
- reset asserted at cycle 15 of an operation → all outputs zero immediately; no done afterwards. A subsequent start with 1000/3 → dout=333, rem=1.
